lif_neuron: RTL and testbench
=============================

Name: lif_neuron

Overview:
Parametrised leaky integrate-and-fire neuron, the successor of the single-weight overflow divider neuron.
- Adds NUM_SYN weighted synapses with writable weight memory, a programmable threshold, a per-step leak and a refractory period.
- Selectable reset mode: reset-to-zero, or subtract-threshold (carry-preserving, divider-compatible).
- Used as the compute element in spiking-network builds driven over the JTAG register interface.
- Fully synchronous; spike output is a registered one-cycle pulse, not clock-gated.

Parameters:
WIDTH, 8, membrane/weight/threshold/leak width in bits (>=2)
NUM_SYN, 4, number of synaptic inputs (>=1)
REFRAC, 2, refractory length in steps after a spike (0 = none)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
step  in  1  integration strobe; one integration per cycle with step=1
syn_in  in  NUM_SYN  input spike vector, sampled on step
wr_en  in  1  weight write strobe
wr_addr  in  max(1,$clog2(NUM_SYN))  weight index; writes with addr>=NUM_SYN ignored
wr_data  in  WIDTH  unsigned weight value
threshold  in  WIDTH  firing threshold, unsigned
leak  in  WIDTH  amount subtracted per integrating step
mode  in  1  0 = reset-to-zero, 1 = subtract-threshold
spike_out  out  1  one-cycle spike pulse
membrane  out  WIDTH  current membrane potential
refractory  out  1  high while refractory counter nonzero

Behaviour:
- Reset (rst=1 at clk edge): membrane=0, all weights=0, refractory counter=0, spike_out=0. Reset dominates wr_en and step in the same cycle. Mid-refractory reset clears the counter.
- Weight write: wr_en=1 updates weight[wr_addr] at the edge. An integration in the same cycle uses the old weight.
- Integration occurs only on cycles with step=1 and refractory=0:
  - sum = Σ weight[i] over syn_in[i]=1, computed at width WIDTH+$clog2(NUM_SYN)+1, no overflow.
  - v = membrane + sum.
  - v_l = (v > leak) ? v - leak : 0 (floor at 0, never wraps).
  - If v_l >= threshold: spike. Next membrane = 0 (mode 0) or min(v_l - threshold, 2^WIDTH-1) (mode 1). Counter loads REFRAC.
  - Else: membrane = min(v_l, 2^WIDTH-1).
- Threshold=0: every integrating step spikes.
- spike_out: high for exactly the one cycle following the integrating edge; otherwise 0. Latency from step to spike_out is 1 cycle.
- Refractory:
  - On step=1 with counter>0: counter decrements.
  - syn_in is ignored, no leak is applied, membrane is held, spike_out=0.
  - refractory = (counter != 0).
- step=0: membrane, counter and outputs are held (spike_out=0).
- mode, threshold and leak are sampled on the integrating edge. Changing them between steps is legal.

Test Plan:
- Reset: assert rst 1 cycle, then step with syn_in=4'b1111 -> membrane=0, spike_out=0, weights read back via behaviour as 0.
- Divider compatibility (REFRAC=0): w0=191, threshold=255, leak=0, mode=1, syn_in=4'b0001, step every cycle -> membrane 191,127,63,254,190; spike_out on steps 2,3,5.
- Leak and mode 0 (REFRAC=2): w0=100, w1=60, threshold=200, leak=10, syn_in=4'b0011 -> membrane 150, then spike with membrane=0, refractory=1 for 2 steps (membrane held 0), next step membrane=150.
- Leak floor: membrane=5, leak=10, syn_in=0, step -> membrane=0, no wrap to 251, no spike.
- Saturation (REFRAC=0): all weights 255, threshold=255, mode=1, syn_in=4'b1111 -> v=1020, spike, membrane saturates to 255. Next step spikes again.
- Write/step collision and mid-refractory reset:
  - wr_en w0=50 in the same cycle as step with w0 previously 20 -> membrane increases by 20. The next step adds 50.
  - rst during refractory=1 -> next cycle refractory=0, membrane=0, spike_out=0.

Source files
------------

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with NUM_SYN weighted synapses.
// Each integrating step sums the weights of the active synapses into the
// membrane, subtracts the leak (floored at zero) and compares against the
// threshold. On a spike the membrane is cleared (mode 0) or reduced by the
// threshold (mode 1, carry-preserving), and a refractory counter is loaded.
// All state lives in one clock domain with a synchronous active-high reset.
module lif_neuron #(
  parameter int WIDTH   = 8,
  parameter int NUM_SYN = 4,
  parameter int REFRAC  = 2,
  localparam int AW     = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               step_i,
  input  logic [NUM_SYN-1:0] syn_in_i,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic [WIDTH-1:0]   threshold_i,
  input  logic [WIDTH-1:0]   leak_i,
  input  logic               mode_i,
  output logic               spike_out_o,
  output logic [WIDTH-1:0]   membrane_o,
  output logic               refractory_o
);

  // Synaptic sum is wide enough that NUM_SYN full-scale weights never overflow;
  // one more bit holds membrane + sum.
  localparam int SUMW = WIDTH + $clog2(NUM_SYN) + 1;
  localparam int VW   = SUMW + 1;
  localparam int CW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic [AW:0]   NSYN_W   = (AW + 1)'(NUM_SYN);
  localparam logic [CW-1:0] REFRAC_W = CW'(REFRAC);

  logic [WIDTH-1:0] w_q [NUM_SYN];
  logic [WIDTH-1:0] mem_q, mem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             spike_q, spike_d;

  logic [SUMW-1:0]  sum_c;
  logic [VW-1:0]    v_c;
  logic [VW-1:0]    vl_c;
  logic [VW-1:0]    resid_c;
  logic             fire_c;
  logic             in_refrac_c;
  logic             wr_ok_c;

  // Clamp a wide intermediate to the largest representable membrane value.
  function automatic logic [WIDTH-1:0] sat_fn(input logic [VW-1:0] x);
    if (|x[VW-1:WIDTH]) return '1;
    return x[WIDTH-1:0];
  endfunction

  // Sum of the weights whose synapse is active this cycle (old weights only).
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_SYN; i++) begin
      if (syn_in_i[i]) sum_c = sum_c + SUMW'(w_q[i]);
    end
  end

  assign v_c = VW'(mem_q) + VW'(sum_c);

  // Leak is applied after integration and floors at zero instead of wrapping.
  always_comb begin
    if (v_c > VW'(leak_i)) vl_c = v_c - VW'(leak_i);
    else                   vl_c = '0;
  end

  assign fire_c      = (vl_c >= VW'(threshold_i));
  assign resid_c     = vl_c - VW'(threshold_i);
  assign in_refrac_c = (cnt_q != '0);
  assign wr_ok_c     = ({1'b0, wr_addr_i} < NSYN_W);

  // Next-state for membrane, refractory counter and spike pulse.
  always_comb begin
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
    if (step_i) begin
      if (in_refrac_c) begin
        cnt_d = cnt_q - CW'(1);
      end else if (fire_c) begin
        spike_d = 1'b1;
        cnt_d   = REFRAC_W;
        mem_d   = mode_i ? sat_fn(resid_c) : '0;
      end else begin
        mem_d   = sat_fn(vl_c);
      end
    end
  end

  // State registers and weight memory; reset wins over writes and steps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q   <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
      for (int i = 0; i < NUM_SYN; i++) w_q[i] <= '0;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
      if (wr_en_i && wr_ok_c) w_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign spike_out_o  = spike_q;
  assign membrane_o   = mem_q;
  assign refractory_o = in_refrac_c;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: one instance without refractory period and
// one with REFRAC=2, both driven from the same inputs.
module tb_lif_neuron;

  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic [3:0] syn_in;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] threshold;
  logic [7:0] leak;
  logic       mode;

  logic       spk0, ref0, spk2, ref2;
  logic [7:0] mem0, mem2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lif_neuron #(.WIDTH(8), .NUM_SYN(4), .REFRAC(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .step_i(step), .syn_in_i(syn_in),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .threshold_i(threshold), .leak_i(leak), .mode_i(mode),
    .spike_out_o(spk0), .membrane_o(mem0), .refractory_o(ref0)
  );

  lif_neuron #(.WIDTH(8), .NUM_SYN(4), .REFRAC(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .step_i(step), .syn_in_i(syn_in),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .threshold_i(threshold), .leak_i(leak), .mode_i(mode),
    .spike_out_o(spk2), .membrane_o(mem2), .refractory_o(ref2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_w(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = 2'(a);
    wr_data = 8'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_step(input logic [3:0] s);
    step   = 1'b1;
    syn_in = s;
    tick();
    step   = 1'b0;
    syn_in = '0;
  endtask

  int exp_mem [5] = '{191, 127, 63, 254, 190};
  int exp_spk [5] = '{0, 1, 1, 0, 1};

  initial begin
    rst = 1'b0; step = 1'b0; syn_in = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; threshold = 8'd10; leak = '0; mode = 1'b0;
    #2;

    // Reset state, then weights must behave as zero.
    do_reset();
    check("rst_mem0", int'(mem0), 0);
    check("rst_spk0", int'(spk0), 0);
    check("rst_ref2", int'(ref2), 0);
    do_step(4'b1111);
    check("rst_step_mem0", int'(mem0), 0);
    check("rst_step_spk0", int'(spk0), 0);
    check("rst_step_mem2", int'(mem2), 0);
    check("rst_step_spk2", int'(spk2), 0);

    // Divider compatibility on the REFRAC=0 instance, step every cycle.
    do_reset();
    write_w(0, 191);
    threshold = 8'd255; leak = 8'd0; mode = 1'b1;
    step = 1'b1; syn_in = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("div_mem[%0d]", k), int'(mem0), exp_mem[k]);
      check($sformatf("div_spk[%0d]", k), int'(spk0), exp_spk[k]);
    end
    step = 1'b0; syn_in = '0;
    tick();
    check("div_spk_idle", int'(spk0), 0);
    check("div_hold", int'(mem0), 190);

    // Leak, mode 0 and refractory on the REFRAC=2 instance.
    do_reset();
    write_w(0, 100);
    write_w(1, 60);
    threshold = 8'd200; leak = 8'd10; mode = 1'b0;
    do_step(4'b0011);
    check("leak_mem_s1", int'(mem2), 150);
    check("leak_spk_s1", int'(spk2), 0);
    do_step(4'b0011);
    check("leak_spk_s2", int'(spk2), 1);
    check("leak_mem_s2", int'(mem2), 0);
    check("leak_ref_s2", int'(ref2), 1);
    tick();
    check("leak_spk_pulse", int'(spk2), 0);
    check("leak_ref_idle", int'(ref2), 1);
    do_step(4'b0011);
    check("refr1_mem", int'(mem2), 0);
    check("refr1_ref", int'(ref2), 1);
    check("refr1_spk", int'(spk2), 0);
    do_step(4'b0011);
    check("refr2_mem", int'(mem2), 0);
    check("refr2_ref", int'(ref2), 0);
    do_step(4'b0011);
    check("post_refr_mem", int'(mem2), 150);
    check("post_refr_spk", int'(spk2), 0);

    // Leak floor and step=0 hold on the REFRAC=0 instance.
    do_reset();
    write_w(0, 15);
    threshold = 8'd200; leak = 8'd10; mode = 1'b0;
    do_step(4'b0001);
    check("floor_pre", int'(mem0), 5);
    syn_in = 4'b0001;
    tick();
    check("hold_nostep", int'(mem0), 5);
    syn_in = '0;
    do_step(4'b0000);
    check("floor_mem", int'(mem0), 0);
    check("floor_spk", int'(spk0), 0);

    // Threshold 0: every integrating step spikes.
    threshold = 8'd0;
    do_step(4'b0000);
    check("thr0_spk", int'(spk0), 1);
    check("thr0_mem", int'(mem0), 0);

    // Saturation in subtract mode.
    do_reset();
    for (int a = 0; a < 4; a++) write_w(a, 255);
    threshold = 8'd255; leak = 8'd0; mode = 1'b1;
    do_step(4'b1111);
    check("sat_spk1", int'(spk0), 1);
    check("sat_mem1", int'(mem0), 255);
    do_step(4'b1111);
    check("sat_spk2", int'(spk0), 1);
    check("sat_mem2", int'(mem0), 255);

    // Weight write colliding with a step uses the old weight.
    do_reset();
    write_w(0, 20);
    threshold = 8'd255; leak = 8'd0; mode = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd50;
    do_step(4'b0001);
    wr_en = 1'b0;
    check("coll_old_w", int'(mem0), 20);
    do_step(4'b0001);
    check("coll_new_w", int'(mem0), 70);

    // Reset in the middle of a refractory period.
    do_reset();
    write_w(0, 200);
    threshold = 8'd100; leak = 8'd0; mode = 1'b1;
    do_step(4'b0001);
    check("mid_spk", int'(spk2), 1);
    check("mid_mem_resid", int'(mem2), 100);
    check("mid_ref", int'(ref2), 1);
    do_reset();
    check("mid_rst_ref", int'(ref2), 0);
    check("mid_rst_mem", int'(mem2), 0);
    check("mid_rst_spk", int'(spk2), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
